fifo_stream_packer: RTL and testbench
=====================================

# fifo_stream_packer

Upstream stage of the common FIFO. Collects `NumWords` consecutive narrow beats from a valid/ready stream into one wide word and pushes that word into the FIFO's `data_i`/`push_i` port, observing the FIFO's `full_o`. Used wherever a narrow producer, such as a memory read port, feeds wide hypervector queues.

## Interface
Parameters:
- `InWidth`, 32, narrow beat width in bits.
- `NumWords`, 4, beats per wide word; must be ≥ 2.
- `OutWidth`, `InWidth*NumWords`, wide word width; derived, do not override.
- `CntWidth`, `$clog2(NumWords)`, beat index width; derived, do not override.

Ports:
- `clk_i` input 1 clock.
- `rst_ni` input 1 reset, asynchronous, active-low.
- `clr_i` input 1 synchronous clear; same effect as reset.
- `data_i` input `InWidth` narrow beat.
- `valid_i` input 1 beat valid.
- `last_i` input 1 beat closes a partial word; used only with `FIFO_STREAM_PACKER_LAST_EN`.
- `ready_o` output 1 beat accepted when `valid_i & ready_o`.
- `data_o` output `OutWidth` wide word to the FIFO `data_i`.
- `push_o` output 1 to the FIFO `push_i`.
- `full_i` input 1 from the FIFO `full_o`.
- `count_o` output `CntWidth` beats currently held in the assembly buffer.

## Operation
- Two storage stages:
  - Assembly buffer `asm_q` (`OutWidth`) with beat index `idx_q`.
  - Output register `out_q` (`OutWidth`) with flag `out_valid_q`.
- Accepted beat k is written to `asm_q[k*InWidth +: InWidth]`. Beat 0 is the LSBs.
- A beat is "closing" when `idx_q == NumWords-1`, or when `last_i` is set with the macro enabled.
- Non-closing accepted beat: `idx_q` increments.
- Closing accepted beat:
  - `out_q` loads `asm_q` merged with the incoming beat.
  - Unfilled slices are zero.
  - `out_valid_q` sets.
  - `asm_q` clears to 0.
  - `idx_q` returns to 0.
- `ready_o = ~(closing_candidate & out_valid_q)`.
  - Non-closing beats are always accepted.
  - A closing beat waits while the output register is occupied, even if it drains that same cycle.
- `push_o = out_valid_q & ~full_i`. `data_o = out_q`.
- When `push_o` is high, `out_valid_q` clears next cycle, unless a closing beat is accepted in the same cycle, which cannot happen by the ready rule.
- `count_o = idx_q`.
- `full_i` never reaches `ready_o` combinationally. `last_i` may reach it.
- `last_i` on a beat at `idx_q == NumWords-1` is redundant and has no extra effect.
- Mid-word reset or `clr_i` discards the partial word and any pending output word.

## Timing
- Reset values:
  - `ready_o` = 1
  - `push_o` = 0
  - `data_o` = 0
  - `count_o` = 0
  - `asm_q`, `idx_q`, `out_valid_q` = 0
- Latency: `push_o` rises the cycle after the closing beat is accepted, provided `full_i` = 0.
- Throughput: one wide word per `NumWords` cycles with no bubbles while the FIFO is not full.
- Backpressure, FIFO full:
  - `out_q` holds stable.
  - Non-closing beats continue to be accepted.
  - `ready_o` drops only when the closing beat is presented.
- `clr_i` takes priority over all handshakes in that cycle.

## Configuration
- `FIFO_STREAM_PACKER_LAST_EN` defined:
  - `last_i` is honoured, so partial words are emitted zero-padded.
  - `last_i` at `idx_q == 0` emits a word containing only that beat.
- Not defined:
  - `last_i` is ignored (port remains for interface stability).
  - Only full `NumWords` words are emitted.

## Structure
- Shared package: a beat-index typedef sized by `CntWidth`, plus the `NumWords ≥ 2` constant check helper.
- No sub-module. The block is a single module: assembly buffer, index counter and one output register.
- Instantiated directly in front of `fifo`:
  - `push_o`→`push_i`
  - `data_o`→`data_i`
  - `full_o`→`full_i`
- Non-synthesis assertions:
  - `NumWords ≥ 2`.
  - `push_o` never asserted while `full_i`.
  - `data_o` stable while `out_valid_q & full_i`.

## Test plan
- Basic pack: InWidth=32, NumWords=4, beats 0x11,0x22,0x33,0x44 on consecutive cycles, `full_i`=0 → one `push_o` pulse the next cycle, `data_o`=0x00000044_00000033_00000022_00000011.
- Streaming: 12 back-to-back beats with `ready_o` held high throughout → exactly 3 pushes, spaced 4 cycles apart.
- Backpressure: hold `full_i`=1 after the first word → `push_o`=0 and `data_o` stable. The next 3 beats are accepted and the 4th sees `ready_o`=0. Drop `full_i` → word pushed, then the 4th beat is accepted one cycle later.
- Clear and reset mid-word: accept 2 beats, pulse `clr_i` → `count_o`=0 and no push. Next 4 beats produce a clean word with no stale data. Repeat the sequence using `rst_ni`.
- Macro on: beats 0xA, 0xB with `last_i` on 0xB → push with `data_o`=0x0…0_0000000B_0000000A (upper slices 0). Macro off, same stimulus → no push, `count_o`=2.

Source files
------------

// File: rtl/fifo_stream_packer_pkg.sv
// Shared types and elaboration helpers for the narrow-to-wide stream packer.
package fifo_stream_packer_pkg;

  localparam int unsigned DefaultInWidth  = 32;
  localparam int unsigned DefaultNumWords = 4;
  localparam int unsigned DefaultCntWidth = $clog2(DefaultNumWords);

  typedef logic [DefaultCntWidth-1:0] beat_idx_t;

  // A packer needs at least two beats per word, otherwise it degenerates to a wire.
  function automatic bit num_words_ok(input int unsigned num_words);
    return num_words >= 2;
  endfunction

endpackage

// File: rtl/fifo_stream_packer.sv
// Packs NumWords narrow valid/ready beats into one wide FIFO word (beat 0 in the LSBs).
// Define FIFO_STREAM_PACKER_LAST_EN to honour last_i and emit zero-padded partial words.
module fifo_stream_packer
  import fifo_stream_packer_pkg::*;
#(
  parameter int unsigned InWidth  = 32,
  parameter int unsigned NumWords = 4,
  parameter int unsigned OutWidth = InWidth * NumWords,
  parameter int unsigned CntWidth = $clog2(NumWords)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic [InWidth-1:0]  data_i,
  input  logic                valid_i,
  input  logic                last_i,
  output logic                ready_o,
  output logic [OutWidth-1:0] data_o,
  output logic                push_o,
  input  logic                full_i,
  output logic [CntWidth-1:0] count_o
);

  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumWords - 1);

  logic [OutWidth-1:0] asm_q;
  logic [CntWidth-1:0] idx_q;
  logic [OutWidth-1:0] out_q;
  logic                out_valid_q;

  logic                closing;
  logic                accept;
  logic [OutWidth-1:0] merged;

`ifdef FIFO_STREAM_PACKER_LAST_EN
  assign closing = (idx_q == LastIdx) | last_i;
`else
  logic unused_last;
  assign unused_last = last_i;
  assign closing     = (idx_q == LastIdx);
`endif

  // A closing beat waits for the output register to be empty at the start of
  // the cycle; full_i is deliberately kept off this path.
  assign ready_o = ~(closing & out_valid_q);
  assign accept  = valid_i & ready_o;
  assign push_o  = out_valid_q & ~full_i;
  assign data_o  = out_q;
  assign count_o = idx_q;

  // Slices above idx_q are always zero in asm_q, so this also zero-pads partial words.
  always_comb begin
    merged = asm_q;
    for (int unsigned k = 0; k < NumWords; k++) begin
      if (idx_q == CntWidth'(k)) begin
        merged[k*InWidth +: InWidth] = data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      asm_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (clr_i) begin
      asm_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (push_o) begin
        out_valid_q <= 1'b0;
      end
      if (accept) begin
        if (closing) begin
          out_q       <= merged;
          out_valid_q <= 1'b1;
          asm_q       <= '0;
          idx_q       <= '0;
        end else begin
          asm_q <= merged;
          idx_q <= idx_q + CntWidth'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_num_words: assert property (@(posedge clk_i) num_words_ok(NumWords))
    else $error("fifo_stream_packer: NumWords must be at least 2");

  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_o && full_i))
    else $error("fifo_stream_packer: push while FIFO full");

  a_data_stable_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (out_valid_q && full_i && !clr_i) |=> $stable(data_o))
    else $error("fifo_stream_packer: data_o changed under backpressure");
`endif

endmodule

// File: tb/tb_fifo_stream_packer.sv
// Scoreboard bench for fifo_stream_packer: a beat model predicts each wide word,
// a negedge monitor pops and compares on every push.
module tb_fifo_stream_packer;
  import fifo_stream_packer_pkg::*;

  localparam int unsigned InWidth  = 32;
  localparam int unsigned NumWords = 4;
  localparam int unsigned OutWidth = InWidth * NumWords;
  localparam int unsigned CntWidth = $clog2(NumWords);
`ifdef FIFO_STREAM_PACKER_LAST_EN
  localparam bit LastEn = 1'b1;
`else
  localparam bit LastEn = 1'b0;
`endif

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                clr_i;
  logic [InWidth-1:0]  data_i;
  logic                valid_i;
  logic                last_i;
  logic                ready_o;
  logic [OutWidth-1:0] data_o;
  logic                push_o;
  logic                full_i;
  logic [CntWidth-1:0] count_o;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int stallCycles = 0;

  logic [OutWidth-1:0] expQ[$];
  int                  pushCycles[$];
  logic [OutWidth-1:0] modelWord;
  int                  modelIdx;

  fifo_stream_packer #(
    .InWidth (InWidth),
    .NumWords(NumWords)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .data_i (data_i),
    .valid_i(valid_i),
    .last_i (last_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .push_o (push_o),
    .full_i (full_i),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycleCount++;

  // Every push is matched against the oldest predicted word.
  always @(negedge clk_i) begin
    if (rst_ni && push_o) begin
      logic [OutWidth-1:0] exp;
      pushCycles.push_back(cycleCount);
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_push data_o=%h (no word expected)", data_o);
      end else begin
        exp = expQ.pop_front();
        if (data_o !== exp) begin
          errors++;
          $display("[TB] FAIL push_data got=%h expected=%h", data_o, exp);
        end
      end
    end
  end

  function automatic void modelClear();
    modelWord = '0;
    modelIdx  = 0;
    expQ.delete();
  endfunction

  function automatic void modelAccept(input logic [InWidth-1:0] d, input bit l);
    modelWord[modelIdx*InWidth +: InWidth] = d;
    if (modelIdx == NumWords - 1 || (LastEn && l)) begin
      expQ.push_back(modelWord);
      modelWord = '0;
      modelIdx  = 0;
    end else begin
      modelIdx++;
    end
  endfunction

  // Drives one beat (called just after a rising edge) and holds it until accepted.
  task automatic applyStimulus(input logic [InWidth-1:0] d, input bit l);
    int waitCycles = 0;
    valid_i = 1'b1;
    data_i  = d;
    last_i  = l;
    @(negedge clk_i);
    while (!ready_o && waitCycles < 50) begin
      @(negedge clk_i);
      waitCycles++;
    end
    stallCycles += waitCycles;
    if (!ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_timeout ready_o=%b required=1 beat=%h", ready_o, d);
    end else begin
      @(posedge clk_i);
      modelAccept(d, l);
    end
    #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    clr_i   = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    data_i  = '0;
    full_i  = 1'b0;
    modelClear();
    repeat (2) @(negedge clk_i);
    checks += 4;
    if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b expected=1", ready_o); end
    if (push_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_push got=%b expected=0", push_o); end
    if (data_o !== '0) begin errors++; $display("[TB] FAIL reset_data got=%h expected=0", data_o); end
    if (count_o !== '0) begin errors++; $display("[TB] FAIL reset_count got=%0d expected=0", count_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    idleCycles(1);
  endtask

  task automatic test_basic_pack();
    beat_idx_t expCount = beat_idx_t'(2);
    applyStimulus(32'h11, 1'b0);
    applyStimulus(32'h22, 1'b0);
    @(negedge clk_i);
    checks += 2;
    if (count_o !== expCount) begin errors++; $display("[TB] FAIL basic_count got=%0d expected=%0d", count_o, expCount); end
    if (push_o !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_push got=%b expected=0", push_o); end
    @(posedge clk_i);
    #1;
    applyStimulus(32'h33, 1'b0);
    applyStimulus(32'h44, 1'b0);
    @(negedge clk_i);
    checks += 2;
    if (push_o !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency push_o=%b expected=1", push_o); end
    if (data_o !== 128'h00000044_00000033_00000022_00000011) begin
      errors++;
      $display("[TB] FAIL basic_data got=%h expected=00000044000000330000002200000011", data_o);
    end
    idleCycles(2);
  endtask

  task automatic test_streaming();
    pushCycles.delete();
    stallCycles = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(32'hA000_0000 + i, 1'b0);
    end
    @(negedge clk_i);
    idleCycles(2);
    checks += 2;
    if (stallCycles != 0) begin errors++; $display("[TB] FAIL stream_stalls got=%0d expected=0", stallCycles); end
    if (pushCycles.size() != 3) begin
      errors++;
      $display("[TB] FAIL stream_push_count got=%0d expected=3", pushCycles.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (pushCycles[i] - pushCycles[i-1] != 4) begin
          errors++;
          $display("[TB] FAIL stream_spacing got=%0d expected=4", pushCycles[i] - pushCycles[i-1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [OutWidth-1:0] heldWord;
    full_i   = 1'b1;
    heldWord = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    applyStimulus(32'hB0B0B0B0, 1'b0);
    applyStimulus(32'hB1B1B1B1, 1'b0);
    applyStimulus(32'hB2B2B2B2, 1'b0);
    applyStimulus(32'hB3B3B3B3, 1'b0);
    stallCycles = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'hC0 + i, 1'b0);
    end
    checks++;
    if (stallCycles != 0) begin errors++; $display("[TB] FAIL bp_nonclosing_stall got=%0d expected=0", stallCycles); end
    valid_i = 1'b1;
    data_i  = 32'hC3;
    @(negedge clk_i);
    checks += 3;
    if (ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready got=%b expected=0", ready_o); end
    if (push_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_push got=%b expected=0", push_o); end
    if (data_o !== heldWord) begin errors++; $display("[TB] FAIL bp_data_hold got=%h expected=%h", data_o, heldWord); end
    @(posedge clk_i);
    #1;
    full_i = 1'b0;
    @(negedge clk_i);
    checks += 2;
    if (push_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_push got=%b expected=1", push_o); end
    if (ready_o !== 1'b0) begin errors++; $display("[TB] FAIL bp_same_cycle_ready got=%b expected=0", ready_o); end
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    checks++;
    if (ready_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_drained_ready got=%b expected=1", ready_o); end
    @(posedge clk_i);
    modelAccept(32'hC3, 1'b0);
    #1;
    valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (push_o !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_push got=%b expected=1", push_o); end
    idleCycles(2);
  endtask

  task automatic test_clear_mid_word();
    applyStimulus(32'hDEAD0001, 1'b0);
    applyStimulus(32'hDEAD0002, 1'b0);
    // A beat presented during the clear must be dropped.
    clr_i   = 1'b1;
    valid_i = 1'b1;
    data_i  = 32'hDEAD0003;
    @(posedge clk_i);
    modelClear();
    #1;
    clr_i   = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    checks += 2;
    if (count_o !== '0) begin errors++; $display("[TB] FAIL clr_count got=%0d expected=0", count_o); end
    if (push_o !== 1'b0) begin errors++; $display("[TB] FAIL clr_push got=%b expected=0", push_o); end
    @(posedge clk_i);
    #1;
    for (int i = 0; i < 4; i++) applyStimulus(32'h5000 + i, 1'b0);
    idleCycles(2);

    applyStimulus(32'hBEEF0001, 1'b0);
    applyStimulus(32'hBEEF0002, 1'b0);
    rst_ni = 1'b0;
    modelClear();
    @(negedge clk_i);
    checks += 2;
    if (count_o !== '0) begin errors++; $display("[TB] FAIL rst_count got=%0d expected=0", count_o); end
    if (push_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_push got=%b expected=0", push_o); end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(32'h6000 + i, 1'b0);
    idleCycles(2);
  endtask

  task automatic test_last();
    applyStimulus(32'hA, 1'b0);
    applyStimulus(32'hB, 1'b1);
    @(negedge clk_i);
    if (LastEn) begin
      checks += 2;
      if (push_o !== 1'b1) begin errors++; $display("[TB] FAIL last_push got=%b expected=1", push_o); end
      if (data_o !== 128'h0000000B_0000000A) begin
        errors++;
        $display("[TB] FAIL last_data got=%h expected=0000000b0000000a", data_o);
      end
      idleCycles(2);
      applyStimulus(32'hE, 1'b1);
      idleCycles(2);
    end else begin
      checks += 2;
      if (push_o !== 1'b0) begin errors++; $display("[TB] FAIL last_ignored_push got=%b expected=0", push_o); end
      if (count_o !== CntWidth'(2)) begin errors++; $display("[TB] FAIL last_ignored_count got=%0d expected=2", count_o); end
      @(posedge clk_i);
      #1;
      applyStimulus(32'hC, 1'b0);
      applyStimulus(32'hD, 1'b0);
      idleCycles(2);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_streaming();
    test_backpressure();
    test_clear_mid_word();
    test_last();
    idleCycles(3);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL words_outstanding got=%0d expected=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
